demux_channel_scheduler: RTL and testbench

Upstream feeder for the four-output 4-bit demux stage. Accepts tagged 4-bit words `{destination, data}` over a valid/ready handshake and buffers them in a small FIFO. Replays them in order onto the demux control bus `Select`/`Signal`/`Enable`. Each word is held on the bus for a programmable number of cycles, with an optional idle gap between words. The demux itself stays purely combinational. This block provides the timing, buffering and back-pressure.

---
 rtl/demux_channel_scheduler.sv | 137 +++++++++++++
 tb/tb_demux_channel_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_channel_scheduler.sv
// Buffers tagged {dest, data} words in a small FIFO and replays them onto the
// demux Select/Signal/Enable bus with a programmable hold time and idle gap.
module demux_channel_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 1,
   parameter int unsigned GAP   = 0
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [1:0]               In_Dest,
   input  logic [3:0]               In_Data,
   input  logic                     Pause,
   output logic [1:0]               Select,
   output logic [3:0]               Signal,
   output logic                     Enable,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Busy
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned MAXC = (HOLD > GAP) ? HOLD : GAP;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [AW:0]   FULL      = DEPTH[AW:0];
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

   typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    sig_q, sig_d;
   logic          en_q, en_d;

   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic [5:0]    head;
   logic          push, pop, start_ok, decide;

   assign In_Ready = (count_q != FULL);
   assign push     = In_Valid && In_Ready;
   assign head     = mem_q[rd_ptr_q];
   assign start_ok = (count_q != '0) && !Pause;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {In_Dest, In_Data};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      sig_d   = sig_q;
      en_d    = en_q;
      pop     = 1'b0;
      decide  = 1'b0;

      unique case (state_q)
         StIdle:  decide = 1'b1;
         StDrive: begin
            if (cnt_q == HOLD_LAST) begin
               if (GAP > 0) begin
                  state_d = StGap;
                  en_d    = 1'b0;
                  sig_d   = '0;
                  cnt_d   = '0;
               end else begin
                  decide = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GAP_LAST) decide = 1'b1;
            else cnt_d = cnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // Word-start rule shared by IDLE, end of DRIVE and end of GAP
      if (decide) begin
         if (start_ok) begin
            pop     = 1'b1;
            state_d = StDrive;
            sel_d   = head[5:4];
            sig_d   = head[3:0];
            en_d    = 1'b1;
            cnt_d   = '0;
         end else begin
            state_d = StIdle;
            en_d    = 1'b0;
            sig_d   = '0;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sel_q   <= '0;
         sig_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         sig_q   <= sig_d;
         en_q    <= en_d;
      end
   end

   assign Select = sel_q;
   assign Signal = sig_q;
   assign Enable = en_q;
   assign Count  = count_q;
   assign Busy   = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_demux_channel_scheduler.sv
// Directed bench for demux_channel_scheduler: three instances cover HOLD=1,
// HOLD=2 and GAP=2 configurations with hand-computed expected bus values.
module tb_demux_channel_scheduler;

   logic Clock = 1'b0;
   logic Reset_n;

   logic       v1, v2, v3, p1, p2, p3;
   logic [1:0] dst1, dst2, dst3;
   logic [3:0] dat1, dat2, dat3;
   logic       rdy1, rdy2, rdy3, en1, en2, en3, busy1, busy2, busy3;
   logic [1:0] sel1, sel2, sel3;
   logic [3:0] sig1, sig2, sig3;
   logic [2:0] cnt1, cnt2, cnt3;

   int checks = 0;
   int errors = 0;

   logic [1:0] fw_dest [5] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
   logic [3:0] fw_data [5] = '{4'h9, 4'h4, 4'hE, 4'h0, 4'h7};
   logic [1:0] ww_dest [10] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [3:0] ww_data [10] = '{4'h1, 4'hF, 4'h6, 4'hA, 4'h3, 4'hC, 4'h8, 4'h0, 4'h5, 4'hB};

   always #5 Clock = ~Clock;

   demux_channel_scheduler #(.DEPTH(4), .HOLD(1), .GAP(0)) u_h1 (
      .Clock(Clock), .Reset_n(Reset_n), .In_Valid(v1), .In_Ready(rdy1), .In_Dest(dst1),
      .In_Data(dat1), .Pause(p1), .Select(sel1), .Signal(sig1), .Enable(en1), .Count(cnt1),
      .Busy(busy1)
   );

   demux_channel_scheduler #(.DEPTH(4), .HOLD(2), .GAP(0)) u_h2 (
      .Clock(Clock), .Reset_n(Reset_n), .In_Valid(v2), .In_Ready(rdy2), .In_Dest(dst2),
      .In_Data(dat2), .Pause(p2), .Select(sel2), .Signal(sig2), .Enable(en2), .Count(cnt2),
      .Busy(busy2)
   );

   demux_channel_scheduler #(.DEPTH(4), .HOLD(1), .GAP(2)) u_g2 (
      .Clock(Clock), .Reset_n(Reset_n), .In_Valid(v3), .In_Ready(rdy3), .In_Dest(dst3),
      .In_Data(dat3), .Pause(p3), .Select(sel3), .Signal(sig3), .Enable(en3), .Count(cnt3),
      .Busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] q[$];
      logic       pushing;
      int         got, sent, maxc;

      // Reset held with random inputs
      Reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v1 = 1'($urandom); v2 = 1'($urandom); v3 = 1'($urandom);
         p1 = 1'($urandom); p2 = 1'($urandom); p3 = 1'($urandom);
         dst1 = 2'($urandom); dst2 = 2'($urandom); dst3 = 2'($urandom);
         dat1 = 4'($urandom); dat2 = 4'($urandom); dat3 = 4'($urandom);
         tick();
      end
      chk("rst_enable", en1, 0);
      chk("rst_signal", sig1, 0);
      chk("rst_select", sel1, 0);
      chk("rst_count", cnt1, 0);
      chk("rst_ready", rdy1, 1);
      chk("rst_busy", busy1, 0);
      chk("rst_enable_g2", en3, 0);
      v1 = 0; v2 = 0; v3 = 0; p1 = 0; p2 = 0; p3 = 0;
      dst1 = 0; dst2 = 0; dst3 = 0; dat1 = 0; dat2 = 0; dat3 = 0;
      #2 Reset_n = 1'b1;

      // Single word, HOLD=1
      v1 = 1; dst1 = 2'd2; dat1 = 4'hA;
      tick();
      v1 = 0;
      chk("single_count_after_push", cnt1, 1);
      chk("single_en_before_pop", en1, 0);
      chk("single_busy", busy1, 1);
      tick();
      chk("single_en", en1, 1);
      chk("single_sel", sel1, 2);
      chk("single_sig", sig1, 4'hA);
      chk("single_count_after_pop", cnt1, 0);
      tick();
      chk("single_en_off", en1, 0);
      chk("single_sig_off", sig1, 0);
      chk("single_sel_kept", sel1, 2);
      chk("single_busy_off", busy1, 0);

      // Back-to-back, HOLD=2
      v2 = 1; dst2 = 2'd0; dat2 = 4'h1;
      tick();
      dst2 = 2'd1; dat2 = 4'h2;
      tick();
      chk("b2b_en_c1", en2, 1);
      chk("b2b_sig_c1", {sel2, sig2}, {2'd0, 4'h1});
      dst2 = 2'd3; dat2 = 4'hF;
      tick();
      v2 = 0;
      chk("b2b_en_c2", en2, 1);
      chk("b2b_sig_c2", {sel2, sig2}, {2'd0, 4'h1});
      chk("b2b_count_c2", cnt2, 2);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("b2b_en_cont", en2, 1);
         chk("b2b_word", {sel2, sig2}, (k < 2) ? {26'd0, 2'd1, 4'h2} : {26'd0, 2'd3, 4'hF});
      end
      tick();
      chk("b2b_en_end", en2, 0);
      chk("b2b_sig_end", sig2, 0);

      // Full FIFO under Pause
      p1 = 1;
      for (int i = 0; i < 4; i++) begin
         v1 = 1; dst1 = fw_dest[i]; dat1 = fw_data[i];
         tick();
         if (i == 2) chk("full_ready_at3", rdy1, 1);
      end
      chk("full_count4", cnt1, 4);
      chk("full_ready0", rdy1, 0);
      chk("full_en_paused", en1, 0);
      dst1 = fw_dest[4]; dat1 = fw_data[4];
      tick();
      chk("full_count_held", cnt1, 4);
      chk("full_ready_held", rdy1, 0);
      p1 = 0;
      tick();
      chk("full_drain0", {en1, sel1, sig1}, {1'b1, fw_dest[0], fw_data[0]});
      chk("full_count_drain0", cnt1, 3);
      chk("full_ready_back", rdy1, 1);
      tick();
      v1 = 0;
      chk("full_drain1", {en1, sel1, sig1}, {1'b1, fw_dest[1], fw_data[1]});
      chk("full_count_drain1", cnt1, 3);
      for (int i = 2; i < 5; i++) begin
         tick();
         chk("full_drain", {en1, sel1, sig1}, {1'b1, fw_dest[i], fw_data[i]});
         chk("full_count_drain", cnt1, 3'(4 - i));
      end
      tick();
      chk("full_en_end", en1, 0);

      // GAP=2 spacing
      v3 = 1; dst3 = 2'd3; dat3 = 4'h6;
      tick();
      dst3 = 2'd1; dat3 = 4'hB;
      tick();
      v3 = 0;
      chk("gap_word_a", {en3, sel3, sig3}, {1'b1, 2'd3, 4'h6});
      tick();
      chk("gap_idle1", {en3, sel3, sig3}, {1'b0, 2'd3, 4'h0});
      tick();
      chk("gap_idle2", {en3, sig3}, {1'b0, 4'h0});
      tick();
      chk("gap_word_b", {en3, sel3, sig3}, {1'b1, 2'd1, 4'hB});
      tick();
      chk("gap_after_b1", en3, 0);
      tick();
      chk("gap_after_b2", {en3, busy3}, {1'b0, 1'b1});
      tick();
      chk("gap_idle_state", {en3, busy3}, {1'b0, 1'b0});

      // Pause asserted while the first word is on the bus
      v3 = 1; dst3 = 2'd2; dat3 = 4'h3;
      tick();
      dst3 = 2'd0; dat3 = 4'hD;
      tick();
      v3 = 0; p3 = 1;
      chk("pause_first_word", {en3, sel3, sig3}, {1'b1, 2'd2, 4'h3});
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("pause_held_en", en3, 0);
         chk("pause_held_count", cnt3, 1);
      end
      chk("pause_busy", busy3, 1);
      p3 = 0;
      tick();
      chk("pause_second_word", {en3, sel3, sig3}, {1'b1, 2'd0, 4'hD});
      chk("pause_count0", cnt3, 0);

      // Pointer wrap with random valid gaps
      got = 0; sent = 0; maxc = 0;
      for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
         if (sent < 10) begin
            v1 = 1'($urandom_range(0, 1)); dst1 = ww_dest[sent]; dat1 = ww_data[sent];
         end else begin
            v1 = 0;
         end
         pushing = v1 && rdy1;
         tick();
         if (en1) begin
            if (q.size() == 0) begin
               chk("wrap_unexpected_word", 1, 0);
            end else begin
               chk("wrap_word", {sel1, sig1}, {26'd0, q[0]});
               chk("wrap_order", {sel1, sig1}, {26'd0, ww_dest[got], ww_data[got]});
               void'(q.pop_front());
            end
            got++;
         end
         if (pushing) begin
            q.push_back({dst1, dat1});
            sent++;
         end
         if (int'(cnt1) > maxc) maxc = int'(cnt1);
      end
      v1 = 0;
      chk("wrap_all_received", got, 10);
      chk("wrap_count_le4", (maxc <= 4), 1);

      // Async reset mid-DRIVE discards queued words
      v2 = 1; dst2 = 2'd2; dat2 = 4'h5;
      tick();
      dst2 = 2'd3; dat2 = 4'h6;
      tick();
      dst2 = 2'd0; dat2 = 4'h7;
      tick();
      v2 = 0;
      chk("mid_drive_en", en2, 1);
      chk("mid_drive_count", cnt2, 2);
      #2 Reset_n = 1'b0;
      #1;
      chk("async_rst_en", en2, 0);
      chk("async_rst_count", cnt2, 0);
      chk("async_rst_sig", sig2, 0);
      chk("async_rst_ready", rdy2, 1);
      #2 Reset_n = 1'b1;
      tick();
      chk("post_rst_en", en2, 0);
      chk("post_rst_busy", busy2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
